// File: rtl/mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_ctrl_if : request/response and external byte-bus bundle for mem_ctrl.
//
// Signals
//   ICMC_en / ICMC_addr           I-cache refill request (level) and block base
//   MCIC_en / MCIC_block          refill done pulse and assembled block
//   LSBMC_en/_wr/_addr/_len/_data load/store request (level) and its operands
//   MCLSB_en / MCLSB_data         load/store done pulse and zero-extended load data
//   mem_din / mem_dout            RAM read byte / RAM write byte
//   mem_a / mem_wr                RAM byte address / write strobe
//   io_buffer_full                UART buffer full (gates IO-region stores)
//
// Modports
//   master : the environment (requesters + RAM/IO) driving requests and read data
//   slave  : the controller answering requests and driving the byte bus
// ---------------------------------------------------------------------------
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 1
);
   localparam int BLOCK_BITS = 32 << BLOCK_WIDTH;

   logic                  ICMC_en;
   logic [ADDR_WIDTH-1:0] ICMC_addr;
   logic                  MCIC_en;
   logic [BLOCK_BITS-1:0] MCIC_block;

   logic                  LSBMC_en;
   logic                  LSBMC_wr;
   logic [ADDR_WIDTH-1:0] LSBMC_addr;
   logic [1:0]            LSBMC_len;
   logic [31:0]           LSBMC_data;
   logic                  MCLSB_en;
   logic [31:0]           MCLSB_data;

   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;
   logic                  io_buffer_full;

   modport master (
      output ICMC_en, ICMC_addr,
      input  MCIC_en, MCIC_block,
      output LSBMC_en, LSBMC_wr, LSBMC_addr, LSBMC_len, LSBMC_data,
      input  MCLSB_en, MCLSB_data,
      output mem_din, io_buffer_full,
      input  mem_dout, mem_a, mem_wr
   );

   modport slave (
      input  ICMC_en, ICMC_addr,
      output MCIC_en, MCIC_block,
      input  LSBMC_en, LSBMC_wr, LSBMC_addr, LSBMC_len, LSBMC_data,
      output MCLSB_en, MCLSB_data,
      input  mem_din, io_buffer_full,
      output mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl : single-port arbiter/sequencer between the I-cache (block refills)
// and the load/store buffer (byte/half/word accesses) and a byte-wide RAM/IO
// bus. Every access is split into sequential byte transfers; read results are
// assembled little-endian and returned with a one-cycle done pulse.
//
// Ports
//   Sys_clk  : clock
//   Sys_rst  : synchronous active-high reset
//   Sys_rdy  : global enable, low = stall (state frozen, mem_wr forced low)
//   bus      : mem_ctrl_if.slave (requests, responses, RAM byte bus, io full)
// ---------------------------------------------------------------------------
module mem_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 1
) (
   input  logic      Sys_clk,
   input  logic      Sys_rst,
   input  logic      Sys_rdy,
   mem_ctrl_if.slave bus
);
   localparam int NB         = 4 << BLOCK_WIDTH;   // bytes per I-cache block
   localparam int BLOCK_BITS = 8 * NB;
   localparam int CW         = $clog2(NB + 1);     // counter must reach NB

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;           // reads: bytes captured, store: bytes issued
   logic [CW-1:0]         nbytes_q, nbytes_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [31:0]           wdata_q, wdata_d;       // store data, shifted down one byte per issue
   logic [BLOCK_BITS-1:0] buf_q, buf_d;           // read assembly buffer
   logic                  primed_q, primed_d;     // mem_a currently points at slot cnt_q
   logic                  last_lsb_q, last_lsb_d; // last grant went to the LSB
   logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
   logic [7:0]            mem_dout_q, mem_dout_d;
   logic                  mem_wr_q, mem_wr_d;
   logic                  mcic_en_q, mcic_en_d;
   logic                  mclsb_en_q, mclsb_en_d;
   logic [BLOCK_BITS-1:0] mcic_block_q, mcic_block_d;
   logic [31:0]           mclsb_data_q, mclsb_data_d;

   logic                  lsb_is_io, store_is_io;
   logic                  ic_elig, lsb_elig, grant_ic, grant_lsb;
   logic [CW-1:0]         lsb_nbytes, cnt_inc;
   logic [BLOCK_BITS-1:0] buf_cap;

   // Arbitration. An IO-region store cannot start while the UART buffer is full,
   // so it must not block the I-cache in the meantime.
   assign lsb_is_io   = (bus.LSBMC_addr[17:16] == 2'b11);
   assign store_is_io = (base_q[17:16] == 2'b11);
   assign ic_elig     = bus.ICMC_en;
   assign lsb_elig    = bus.LSBMC_en && !(bus.LSBMC_wr && lsb_is_io && bus.io_buffer_full);
   assign grant_ic    = ic_elig && (!lsb_elig || last_lsb_q);
   assign grant_lsb   = lsb_elig && !grant_ic;

   always_comb begin
      case (bus.LSBMC_len)
         2'd0:    lsb_nbytes = CW'(1);
         2'd1:    lsb_nbytes = CW'(2);
         default: lsb_nbytes = CW'(4);
      endcase
   end

   assign cnt_inc = cnt_q + CW'(1);

   // Assembly buffer with the incoming byte dropped into slot cnt_q.
   for (genvar gi = 0; gi < NB; gi++) begin : g_slot
      assign buf_cap[8*gi +: 8] = (cnt_q == CW'(gi)) ? bus.mem_din : buf_q[8*gi +: 8];
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      nbytes_d     = nbytes_q;
      base_d       = base_q;
      wdata_d      = wdata_q;
      buf_d        = buf_q;
      primed_d     = primed_q;
      last_lsb_d   = last_lsb_q;
      mem_a_d      = mem_a_q;
      mem_dout_d   = mem_dout_q;
      mem_wr_d     = 1'b0;
      mcic_en_d    = mcic_en_q;
      mclsb_en_d   = mclsb_en_q;
      mcic_block_d = mcic_block_q;
      mclsb_data_d = mclsb_data_q;

      if (!Sys_rdy) begin
         // Stall: hold everything; in read states point at the next uncaptured
         // byte and force a re-prime edge before capturing resumes.
         if (state_q == FETCH || state_q == LOAD) begin
            mem_a_d  = base_q + ADDR_WIDTH'(cnt_q);
            primed_d = 1'b0;
         end
      end else begin
         mcic_en_d  = 1'b0;
         mclsb_en_d = 1'b0;
         case (state_q)
            IDLE: begin
               // A done pulse still high marks the response cycle: no grant, so
               // a requester that has not yet dropped its level is not re-served.
               if (!mcic_en_q && !mclsb_en_q && (grant_ic || grant_lsb)) begin
                  cnt_d    = '0;
                  primed_d = 1'b1;
                  buf_d    = '0;
                  if (grant_ic) begin
                     state_d    = FETCH;
                     base_d     = bus.ICMC_addr;
                     nbytes_d   = CW'(NB);
                     last_lsb_d = 1'b0;
                     mem_a_d    = bus.ICMC_addr;
                  end else begin
                     base_d     = bus.LSBMC_addr;
                     nbytes_d   = lsb_nbytes;
                     last_lsb_d = 1'b1;
                     mem_a_d    = bus.LSBMC_addr;
                     if (bus.LSBMC_wr) begin
                        // Byte 0 goes out on the grant edge itself.
                        state_d    = STORE;
                        mem_dout_d = bus.LSBMC_data[7:0];
                        wdata_d    = {8'h00, bus.LSBMC_data[31:8]};
                        mem_wr_d   = 1'b1;
                        cnt_d      = CW'(1);
                     end else begin
                        state_d = LOAD;
                     end
                  end
               end
            end

            FETCH, LOAD: begin
               if (primed_q) begin
                  buf_d = buf_cap;
                  if (cnt_q == nbytes_q - CW'(1)) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     if (state_q == FETCH) begin
                        mcic_en_d    = 1'b1;
                        mcic_block_d = buf_cap;
                     end else begin
                        mclsb_en_d   = 1'b1;
                        mclsb_data_d = buf_cap[31:0];
                     end
                  end else begin
                     cnt_d   = cnt_inc;
                     mem_a_d = base_q + ADDR_WIDTH'(cnt_inc);
                  end
               end else begin
                  // Re-prime after a stall: present the address, capture nothing.
                  primed_d = 1'b1;
                  mem_a_d  = base_q + ADDR_WIDTH'(cnt_q);
               end
            end

            STORE: begin
               if (cnt_q == nbytes_q) begin
                  state_d    = IDLE;
                  cnt_d      = '0;
                  mclsb_en_d = 1'b1;
               end else if (!(store_is_io && bus.io_buffer_full)) begin
                  mem_a_d    = base_q + ADDR_WIDTH'(cnt_q);
                  mem_dout_d = wdata_q[7:0];
                  wdata_d    = wdata_q >> 8;
                  mem_wr_d   = 1'b1;
                  cnt_d      = cnt_inc;
               end
               // else: UART full, retry the same byte on a later edge
            end

            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Sys_clk) begin
      if (Sys_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         nbytes_q     <= '0;
         base_q       <= '0;
         wdata_q      <= '0;
         buf_q        <= '0;
         primed_q     <= 1'b0;
         last_lsb_q   <= 1'b1;
         mem_a_q      <= '0;
         mem_dout_q   <= '0;
         mem_wr_q     <= 1'b0;
         mcic_en_q    <= 1'b0;
         mclsb_en_q   <= 1'b0;
         mcic_block_q <= '0;
         mclsb_data_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         nbytes_q     <= nbytes_d;
         base_q       <= base_d;
         wdata_q      <= wdata_d;
         buf_q        <= buf_d;
         primed_q     <= primed_d;
         last_lsb_q   <= last_lsb_d;
         mem_a_q      <= mem_a_d;
         mem_dout_q   <= mem_dout_d;
         mem_wr_q     <= mem_wr_d;
         mcic_en_q    <= mcic_en_d;
         mclsb_en_q   <= mclsb_en_d;
         mcic_block_q <= mcic_block_d;
         mclsb_data_q <= mclsb_data_d;
      end
   end

   assign bus.MCIC_en    = mcic_en_q;
   assign bus.MCIC_block = mcic_block_q;
   assign bus.MCLSB_en   = mclsb_en_q;
   assign bus.MCLSB_data = mclsb_data_q;
   assign bus.mem_a      = mem_a_q;
   assign bus.mem_dout   = mem_dout_q;
   assign bus.mem_wr     = mem_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl : directed testbench for mem_ctrl. A byte RAM model answers
// reads combinationally from mem_a (captured by the DUT one edge later);
// writes are logged by a monitor. Each directed transaction prints one line.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   n_vec  = 0;
   int   n_miss = 0;

   mem_ctrl_if #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1)) bus ();

   logic [7:0]  ram [0:262143];
   int          ic_pulses  = 0;
   int          lsb_pulses = 0;
   int          wr_count   = 0;
   logic [31:0] last_wr_a  = '0;
   logic [7:0]  last_wr_d  = '0;

   mem_ctrl #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1)) dut (
      .Sys_clk (clk),
      .Sys_rst (rst),
      .Sys_rdy (rdy),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_din = ram[bus.mem_a[17:0]];

   always @(negedge clk) begin
      if (bus.MCIC_en)  ic_pulses  <= ic_pulses + 1;
      if (bus.MCLSB_en) lsb_pulses <= lsb_pulses + 1;
      if (bus.mem_wr) begin
         wr_count  <= wr_count + 1;
         last_wr_a <= bus.mem_a;
         last_wr_d <= bus.mem_dout;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ic_c, l_c, w_c, c, w0, l0, i0;
      logic [7:0] st_bytes [4];
      st_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

      rst = 1'b1;
      rdy = 1'b1;
      bus.ICMC_en        = 1'b0;
      bus.ICMC_addr      = '0;
      bus.LSBMC_en       = 1'b0;
      bus.LSBMC_wr       = 1'b0;
      bus.LSBMC_addr     = '0;
      bus.LSBMC_len      = 2'd0;
      bus.LSBMC_data     = '0;
      bus.io_buffer_full = 1'b0;
      ram[18'h01000] = 8'h13; ram[18'h01001] = 8'h00;
      ram[18'h01002] = 8'h00; ram[18'h01003] = 8'h00;
      ram[18'h01004] = 8'h93; ram[18'h01005] = 8'h00;
      ram[18'h01006] = 8'h10; ram[18'h01007] = 8'h00;
      ram[18'h02002] = 8'hFE; ram[18'h02003] = 8'hFF;

      // ---------------- reset state
      tick(); tick();
      check("rst_mcic_en",  64'(bus.MCIC_en), 64'd0);
      check("rst_mclsb_en", 64'(bus.MCLSB_en), 64'd0);
      check("rst_mem_wr",   64'(bus.mem_wr), 64'd0);
      check("rst_mem_a",    64'(bus.mem_a), 64'd0);
      check("rst_mem_dout", 64'(bus.mem_dout), 64'd0);
      check("rst_block",    64'(bus.MCIC_block), 64'd0);
      check("rst_lsb_data", 64'(bus.MCLSB_data), 64'd0);
      rst = 1'b0;
      tick();
      $display("reset released");

      // ---------------- block fetch
      bus.ICMC_en   = 1'b1;
      bus.ICMC_addr = 32'h1000;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("fetch_a",  64'(bus.mem_a), 64'(32'h1000 + k));
         check("fetch_en", 64'(bus.MCIC_en), 64'd0);
      end
      tick();
      check("fetch_done",  64'(bus.MCIC_en), 64'd1);
      check("fetch_block", 64'(bus.MCIC_block), 64'h00100093_00000013);
      bus.ICMC_en = 1'b0;
      tick();
      check("fetch_pulse1", 64'(bus.MCIC_en), 64'd0);
      check("fetch_hold",   64'(bus.MCIC_block), 64'h00100093_00000013);
      $display("fetch  addr=00001000 block=%h", bus.MCIC_block);

      // ---------------- load half
      bus.LSBMC_en   = 1'b1;
      bus.LSBMC_wr   = 1'b0;
      bus.LSBMC_addr = 32'h2002;
      bus.LSBMC_len  = 2'd1;
      tick();
      tick();
      check("ldh_early", 64'(bus.MCLSB_en), 64'd0);
      tick();
      check("ldh_done", 64'(bus.MCLSB_en), 64'd1);
      check("ldh_data", 64'(bus.MCLSB_data), 64'h0000FFFE);
      bus.LSBMC_en = 1'b0;
      tick();
      check("ldh_pulse1", 64'(bus.MCLSB_en), 64'd0);
      check("ldh_no_wr",  64'(wr_count), 64'd0);
      $display("load   addr=00002002 len=1 data=%h", bus.MCLSB_data);

      // ---------------- store word
      bus.LSBMC_en   = 1'b1;
      bus.LSBMC_wr   = 1'b1;
      bus.LSBMC_addr = 32'h3000;
      bus.LSBMC_len  = 2'd2;
      bus.LSBMC_data = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("stw_wr",   64'(bus.mem_wr), 64'd1);
         check("stw_a",    64'(bus.mem_a), 64'(32'h3000 + k));
         check("stw_dout", 64'(bus.mem_dout), 64'(st_bytes[k]));
      end
      tick();
      check("stw_wr_end", 64'(bus.mem_wr), 64'd0);
      check("stw_done",   64'(bus.MCLSB_en), 64'd1);
      bus.LSBMC_en = 1'b0;
      tick();
      $display("store  addr=00003000 len=2 data=deadbeef");

      // ---------------- contention from reset
      rst = 1'b1;
      bus.ICMC_en    = 1'b1;
      bus.ICMC_addr  = 32'h1000;
      bus.LSBMC_en   = 1'b1;
      bus.LSBMC_wr   = 1'b0;
      bus.LSBMC_addr = 32'h2002;
      bus.LSBMC_len  = 2'd0;
      tick(); tick();
      rst = 1'b0;
      i0 = ic_pulses; l0 = lsb_pulses;
      ic_c = -1; l_c = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (bus.MCIC_en && ic_c < 0) begin ic_c = k; bus.ICMC_en = 1'b0; end
         if (bus.MCLSB_en && l_c < 0) begin l_c = k; bus.LSBMC_en = 1'b0; end
      end
      check("cont_ic_cycle",  64'(ic_c), 64'd9);
      check("cont_lsb_cycle", 64'(l_c), 64'd12);
      check("cont_ic_once",   64'(ic_pulses - i0), 64'd1);
      check("cont_lsb_once",  64'(lsb_pulses - l0), 64'd1);
      check("cont_lsb_data",  64'(bus.MCLSB_data), 64'h000000FE);
      $display("contend ic_done=%0d lsb_done=%0d", ic_c, l_c);

      // ---------------- fetch with a 3-cycle stall after byte 2
      bus.ICMC_en   = 1'b1;
      bus.ICMC_addr = 32'h1000;
      repeat (4) tick();
      check("stall_a_pre", 64'(bus.mem_a), 64'h1003);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_a",  64'(bus.mem_a), 64'h1003);
         check("stall_en", 64'(bus.MCIC_en), 64'd0);
      end
      rdy = 1'b1;
      tick();
      check("stall_reprime", 64'(bus.mem_a), 64'h1003);
      c = 0;
      while (c < 20 && !bus.MCIC_en) begin
         tick();
         c++;
      end
      check("stall_latency", 64'(c), 64'd5);
      check("stall_block",   64'(bus.MCIC_block), 64'h00100093_00000013);
      bus.ICMC_en = 1'b0;
      tick();
      $display("stalled fetch addr=00001000 block=%h", bus.MCIC_block);

      // ---------------- IO store blocked by full UART; I-cache served meanwhile
      bus.io_buffer_full = 1'b1;
      bus.LSBMC_en   = 1'b1;
      bus.LSBMC_wr   = 1'b1;
      bus.LSBMC_addr = 32'h30000;
      bus.LSBMC_len  = 2'd0;
      bus.LSBMC_data = 32'h0000005A;
      bus.ICMC_en    = 1'b1;
      bus.ICMC_addr  = 32'h1000;
      w0 = wr_count;
      ic_c = -1; l_c = -1; w_c = -1;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (k == 5) bus.io_buffer_full = 1'b0;
         if (bus.MCIC_en && ic_c < 0) begin ic_c = k; bus.ICMC_en = 1'b0; end
         if (bus.mem_wr && w_c < 0) w_c = k;
         if (bus.MCLSB_en && l_c < 0) begin l_c = k; bus.LSBMC_en = 1'b0; end
      end
      check("io_ic_cycle",  64'(ic_c), 64'd9);
      check("io_wr_cycle",  64'(w_c), 64'd11);
      check("io_done",      64'(l_c), 64'd12);
      check("io_wr_count",  64'(wr_count - w0), 64'd1);
      check("io_wr_addr",   64'(last_wr_a), 64'h30000);
      check("io_wr_data",   64'(last_wr_d), 64'h5A);
      $display("io store addr=00030000 data=5a wr_cycle=%0d", w_c);

      // ---------------- IO word store with UART full mid-transfer
      bus.LSBMC_en   = 1'b1;
      bus.LSBMC_wr   = 1'b1;
      bus.LSBMC_addr = 32'h30004;
      bus.LSBMC_len  = 2'd2;
      bus.LSBMC_data = 32'h11223344;
      tick();
      check("iow_b0_wr",   64'(bus.mem_wr), 64'd1);
      check("iow_b0_dout", 64'(bus.mem_dout), 64'h44);
      bus.io_buffer_full = 1'b1;
      tick();
      check("iow_hold1", 64'(bus.mem_wr), 64'd0);
      tick();
      check("iow_hold2", 64'(bus.mem_wr), 64'd0);
      bus.io_buffer_full = 1'b0;
      tick();
      check("iow_b1_wr",   64'(bus.mem_wr), 64'd1);
      check("iow_b1_a",    64'(bus.mem_a), 64'h30005);
      check("iow_b1_dout", 64'(bus.mem_dout), 64'h33);
      tick();
      check("iow_b2_dout", 64'(bus.mem_dout), 64'h22);
      tick();
      check("iow_b3_a",    64'(bus.mem_a), 64'h30007);
      check("iow_b3_dout", 64'(bus.mem_dout), 64'h11);
      tick();
      check("iow_done",   64'(bus.MCLSB_en), 64'd1);
      check("iow_wr_end", 64'(bus.mem_wr), 64'd0);
      bus.LSBMC_en = 1'b0;
      tick();
      $display("io store addr=00030004 len=2 data=11223344");

      // ---------------- reset in the middle of a store
      l0 = lsb_pulses;
      bus.LSBMC_en   = 1'b1;
      bus.LSBMC_wr   = 1'b1;
      bus.LSBMC_addr = 32'h3100;
      bus.LSBMC_len  = 2'd2;
      bus.LSBMC_data = 32'h01020304;
      tick();
      tick();
      check("rstst_wr_mid", 64'(bus.mem_wr), 64'd1);
      rst = 1'b1;
      bus.LSBMC_en = 1'b0;
      tick();
      check("rstst_wr_off", 64'(bus.mem_wr), 64'd0);
      rst = 1'b0;
      repeat (4) tick();
      check("rstst_no_done", 64'(lsb_pulses - l0), 64'd0);
      check("rstst_wr_idle", 64'(bus.mem_wr), 64'd0);
      // Controller must be back in IDLE: a byte load completes with normal latency.
      bus.LSBMC_en   = 1'b1;
      bus.LSBMC_wr   = 1'b0;
      bus.LSBMC_addr = 32'h2003;
      bus.LSBMC_len  = 2'd0;
      tick();
      tick();
      check("rstst_ld_done", 64'(bus.MCLSB_en), 64'd1);
      check("rstst_ld_data", 64'(bus.MCLSB_data), 64'h000000FF);
      bus.LSBMC_en = 1'b0;
      tick();
      $display("reset mid-store addr=00003100, then load addr=00002003 data=%h", bus.MCLSB_data);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
